// File: rtl/fwd_track.sv
// fwd_track: operand-forwarding tracker for DEPTH in-flight producers.
// Resolves NRD read ports, raises load-use stall, drives RF writeback.
module fwd_track #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic [DEPTH-1:0]        flush_mask,
    input  logic                    iss_wen,
    input  logic [ADDR_W-1:0]       iss_waddr,
    input  logic [DEPTH-1:0]        stg_done,
    input  logic [DEPTH*DATA_W-1:0] stg_data,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    input  logic [NRD*DATA_W-1:0]   rf_data,
    output logic [NRD*DATA_W-1:0]   op_data,
    output logic                    op_stall,
    output logic                    wb_en,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    err
);

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DEPTH-1:0]  rdy_q, rdy_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              err_q, err_d;

    logic [DEPTH-1:0]  cap;
    logic              ret;

    // A result is captured only by a live entry that has none yet.
    assign cap = stg_done & v_q & ~rdy_q;
    assign ret = ~hold & v_q[DEPTH-1];

    // Next state of the tracking shift register and writeback port.
    always_comb begin
        v_d   = v_q;
        rdy_d = rdy_q;
        for (int k = 0; k < DEPTH; k++) begin
            addr_d[k] = addr_q[k];
            data_d[k] = data_q[k];
        end
        if (hold) begin
            for (int k = 0; k < DEPTH; k++) begin
                rdy_d[k] = rdy_q[k] | (stg_done[k] & v_q[k]);
                if (cap[k]) data_d[k] = stg_data[k*DATA_W +: DATA_W];
            end
        end else begin
            v_d[0]    = iss_wen & (|iss_waddr);
            addr_d[0] = iss_waddr;
            rdy_d[0]  = 1'b0;
            data_d[0] = '0;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1];
                addr_d[k] = addr_q[k-1];
                rdy_d[k]  = rdy_q[k-1] | (stg_done[k-1] & v_q[k-1]);
                data_d[k] = cap[k-1] ? stg_data[(k-1)*DATA_W +: DATA_W]
                                     : data_q[k-1];
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_mask[k]) begin
                v_d[k]   = 1'b0;
                rdy_d[k] = 1'b0;
            end
        end

        wb_en_d   = ret;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        if (ret) begin
            wb_addr_d = addr_q[DEPTH-1];
            if (rdy_q[DEPTH-1]) begin
                wb_data_d = data_q[DEPTH-1];
            end else if (stg_done[DEPTH-1]) begin
                wb_data_d = stg_data[(DEPTH-1)*DATA_W +: DATA_W];
            end else begin
                wb_data_d = '0;
                err_d     = 1'b1;
            end
        end
    end

    // State registers; reset discards all in-flight producers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            rdy_q     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            v_q       <= v_d;
            rdy_q     <= rdy_d;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
                data_q[k] <= data_d[k];
            end
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    // Per-port operand resolution, youngest producer wins.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic              unav;
        logic [DATA_W-1:0] val;
        op_data  = '0;
        op_stall = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a    = rd_addr[i*ADDR_W +: ADDR_W];
            hit  = 1'b0;
            unav = 1'b0;
            val  = rf_data[i*DATA_W +: DATA_W];
            if (a == '0) begin
                val = '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!hit && v_q[k] && addr_q[k] == a) begin
                        hit = 1'b1;
                        if (rdy_q[k]) begin
                            val = data_q[k];
                        end else if (stg_done[k]) begin
                            val = stg_data[k*DATA_W +: DATA_W];
                        end else begin
                            unav = 1'b1;
                            val  = '0;
                        end
                    end
                end
                if (!hit && wb_en_q && wb_addr_q == a) val = wb_data_q;
            end
            op_data[i*DATA_W +: DATA_W] = val;
            op_stall = op_stall | (rd_en[i] & unav);
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fwd_track.sv
// tb_fwd_track: scoreboard bench for fwd_track.
// Directed scenarios then randomized traffic against a reference model.
module tb_fwd_track;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int N  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              hold = 1'b0;
    logic [D-1:0]      flush_mask = '0;
    logic              iss_wen = 1'b0;
    logic [AW-1:0]     iss_waddr = '0;
    logic [D-1:0]      stg_done = '0;
    logic [D*DW-1:0]   stg_data = '0;
    logic [N-1:0]      rd_en = '0;
    logic [N*AW-1:0]   rd_addr = '0;
    logic [N*DW-1:0]   rf_data = '0;
    logic [N*DW-1:0]   op_data;
    logic              op_stall;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              err;

    fwd_track #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NRD(N)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush_mask(flush_mask),
        .iss_wen(iss_wen), .iss_waddr(iss_waddr),
        .stg_done(stg_done), .stg_data(stg_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .op_data(op_data), .op_stall(op_stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: a list of in-flight instructions, index = stage.
    typedef struct {
        bit          v;
        bit [AW-1:0] addr;
        bit          has;
        bit [DW-1:0] res;
    } instr_t;

    typedef struct {
        bit [N*DW-1:0] op;
        bit            stall;
        bit            wen;
        bit [AW-1:0]   wa;
        bit [DW-1:0]   wd;
        bit            err;
    } exp_t;

    instr_t      pipe [D];
    bit          m_wen;
    bit [AW-1:0] m_waddr;
    bit [DW-1:0] m_wdata;
    bit          m_err;
    exp_t        sbq [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic bit [DW-1:0] sd(int k);
        return stg_data[k*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) pipe[k] = '{0, 0, 0, 0};
        m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.op = '0;
        e.stall = 0;
        for (int i = 0; i < N; i++) begin
            bit [AW-1:0] a;
            bit [DW-1:0] val;
            bit found;
            bit miss;
            a = rd_addr[i*AW +: AW];
            val = rf_data[i*DW +: DW];
            found = 0;
            miss = 0;
            if (a == 0) val = 0;
            else begin
                for (int k = 0; k < D; k++) begin
                    if (!found && pipe[k].v && pipe[k].addr == a) begin
                        found = 1;
                        if (pipe[k].has) val = pipe[k].res;
                        else if (stg_done[k]) val = sd(k);
                        else begin miss = 1; val = 0; end
                    end
                end
                if (!found && m_wen && m_waddr == a) val = m_wdata;
            end
            e.op[i*DW +: DW] = val;
            if (rd_en[i] && miss) e.stall = 1;
        end
        e.wen = m_wen; e.wa = m_waddr; e.wd = m_wdata; e.err = m_err;
        return e;
    endfunction

    task automatic model_step();
        instr_t old [D];
        for (int k = 0; k < D; k++) begin
            old[k] = pipe[k];
            if (old[k].v && !old[k].has && stg_done[k]) begin
                old[k].has = 1;
                old[k].res = sd(k);
            end
        end
        m_wen = 0;
        if (hold) begin
            for (int k = 0; k < D; k++) pipe[k] = old[k];
        end else begin
            if (old[D-1].v) begin
                m_wen = 1;
                m_waddr = old[D-1].addr;
                m_wdata = old[D-1].has ? old[D-1].res : 0;
                if (!old[D-1].has) m_err = 1;
            end
            for (int k = D-1; k > 0; k--) pipe[k] = old[k-1];
            pipe[0] = '{iss_wen && iss_waddr != 0, iss_waddr, 0, 0};
        end
        for (int k = 0; k < D; k++)
            if (flush_mask[k]) begin pipe[k].v = 0; pipe[k].has = 0; end
    endtask

    // Record this cycle's expectation, then advance the model.
    task automatic go();
        if (!rst_n) model_reset();
        sbq.push_back(predict());
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hold = 0; flush_mask = '0; iss_wen = 0; iss_waddr = '0;
        stg_done = '0; stg_data = '0; rd_en = '0; rd_addr = '0;
        rf_data = {$urandom, $urandom};
    endtask

    task automatic rd(int p, bit [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic done(int k, bit [DW-1:0] d);
        stg_done[k] = 1'b1;
        stg_data[k*DW +: DW] = d;
    endtask

    task automatic issue(bit [AW-1:0] a);
        iss_wen = 1'b1;
        iss_waddr = a;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("op_data", 64'(op_data), 64'(e.op));
                chk("op_stall", 64'(op_stall), 64'(e.stall));
                chk("wb_en", 64'(wb_en), 64'(e.wen));
                chk("wb_addr", 64'(wb_addr), 64'(e.wa));
                chk("wb_data", 64'(wb_data), 64'(e.wd));
                chk("err", 64'(err), 64'(e.err));
            end
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle(); rd(0, 5'd3); rd(1, 5'd0); go();
        idle(); go();
        rst_n = 1'b1;

        // forward r5 through all stages, then writeback
        idle(); issue(5'd5); go();
        idle(); done(0, 32'h1234); rd(0, 5'd5); go();
        idle(); rd(0, 5'd5); go();
        idle(); rd(0, 5'd5); go();
        idle(); rd(0, 5'd5); go();

        // load-use stall resolved after one held cycle
        idle(); issue(5'd7); go();
        idle(); hold = 1; rd(1, 5'd7); go();
        idle(); done(0, 32'hBEEF); rd(1, 5'd7); go();
        repeat (4) begin idle(); go(); end

        // two producers of r3, youngest wins; r0 never allocates
        idle(); issue(5'd3); go();
        idle(); done(0, 32'hB); go();
        idle(); issue(5'd3); go();
        idle(); hold = 1; done(0, 32'hA); rd(0, 5'd3); go();
        idle(); hold = 1; rd(0, 5'd3); rd(1, 5'd0); go();
        idle(); issue(5'd0); rd(1, 5'd0); go();
        repeat (4) begin idle(); rd(1, 5'd0); go(); end

        // flush r9 in entries 0 and 1
        idle(); issue(5'd9); go();
        idle(); issue(5'd9); go();
        idle(); hold = 1; flush_mask = 3'b011; rd(0, 5'd9); go();
        repeat (5) begin idle(); rd(0, 5'd9); go(); end

        // retire without a result sets sticky err
        idle(); issue(5'd4); go();
        repeat (6) begin idle(); rd(1, 5'd4); go(); end

        // mid-flight reset discards everything
        idle(); issue(5'd1); go();
        idle(); issue(5'd2); go();
        idle(); issue(5'd6); go();
        idle(); rst_n = 1'b0; rd(0, 5'd2); rd(1, 5'd6); go();
        rst_n = 1'b1;
        repeat (5) begin idle(); rd(0, 5'd1); go(); end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) flush_mask = D'($urandom);
            iss_wen = $urandom_range(0, 1) == 1;
            iss_waddr = AW'($urandom_range(0, 7));
            for (int k = 0; k < D; k++)
                if (!pipe[k].has && $urandom_range(0, 2) == 0)
                    done(k, $urandom);
            rd_en = N'($urandom);
            for (int p = 0; p < N; p++)
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            go();
        end
        rst_n = 1'b1;
        idle(); go();

        for (int w = 0; w < 20 && sbq.size() != 0; w++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
